// File: rtl/bench_seq_pattern_ctrl.sv
// Pattern sequencer for the XOR-accumulate benchmark datapath.
// Applies one pattern per handshake, captures the response, folds it into a MISR.
module bench_seq_pattern_ctrl #(
   parameter int              IN_W     = 19,
   parameter int              OUT_W    = 11,
   parameter logic [OUT_W-1:0] SIG_POLY = 11'h005
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pat_valid,
   output logic             pat_ready,
   input  logic [IN_W-1:0]  pat_data,
   input  logic             pat_last,
   input  logic [3:0]       pat_hold,
   output logic [IN_W-1:0]  dut_in,
   input  logic [OUT_W-1:0] dut_out,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [OUT_W-1:0] rsp_data,
   output logic [OUT_W-1:0] sig,
   output logic             sig_valid,
   output logic             busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_APPLY,
      S_WAIT,
      S_CAPTURE,
      S_RESP,
      S_DONE
   } state_t;

   state_t      state;
   logic        last_q;
   logic [3:0]  hold_q;
   logic [3:0]  cnt;
   logic        first;
   logic [OUT_W-1:0] sig_fb;

   assign sig_fb = {sig[OUT_W-2:0], 1'b0} ^ (sig[OUT_W-1] ? SIG_POLY : '0);

   // dut_in doubles as the latched pattern; it is only non-zero in APPLY.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= S_IDLE;
         last_q    <= 1'b0;
         hold_q    <= '0;
         cnt       <= '0;
         first     <= 1'b1;
         pat_ready <= 1'b1;
         dut_in    <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         sig       <= '0;
         sig_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (pat_valid) begin
                  dut_in    <= pat_data;
                  last_q    <= pat_last;
                  hold_q    <= pat_hold;
                  if (first) begin
                     sig   <= '0;
                     first <= 1'b0;
                  end
                  pat_ready <= 1'b0;
                  busy      <= 1'b1;
                  state     <= S_APPLY;
               end
            end
            S_APPLY: begin
               dut_in <= '0;
               if (hold_q != 4'd0) begin
                  cnt   <= hold_q;
                  state <= S_WAIT;
               end else begin
                  state <= S_CAPTURE;
               end
            end
            S_WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1)
                  state <= S_CAPTURE;
            end
            S_CAPTURE: begin
               rsp_data  <= dut_out;
               sig       <= sig_fb ^ dut_out;
               rsp_valid <= 1'b1;
               state     <= S_RESP;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (last_q) begin
                     sig_valid <= 1'b1;
                     state     <= S_DONE;
                  end else begin
                     pat_ready <= 1'b1;
                     busy      <= 1'b0;
                     state     <= S_IDLE;
                  end
               end
            end
            S_DONE: begin
               sig_valid <= 1'b0;
               first     <= 1'b1;
               pat_ready <= 1'b1;
               busy      <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bench_seq_pattern_ctrl.sv
// Bench for bench_seq_pattern_ctrl: directed cases plus random sequences
// against a transaction-level model of the XOR datapath and MISR.
module tb_bench_seq_pattern_ctrl;

   localparam int IN_W  = 19;
   localparam int OUT_W = 11;

   logic             clk;
   logic             rst_n;
   logic             pat_valid;
   logic             pat_ready;
   logic [IN_W-1:0]  pat_data;
   logic             pat_last;
   logic [3:0]       pat_hold;
   logic [IN_W-1:0]  dut_in;
   logic [OUT_W-1:0] dut_out;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [OUT_W-1:0] rsp_data;
   logic [OUT_W-1:0] sig;
   logic             sig_valid;
   logic             busy;

   logic [IN_W-1:0]  dp;

   int n_cmp = 0;
   int n_err = 0;

   logic [IN_W-1:0]  m_acc;
   logic [OUT_W-1:0] m_sig;
   logic             m_first;
   logic [OUT_W-1:0] last_rsp;
   logic [OUT_W-1:0] last_sig;

   bench_seq_pattern_ctrl dut (
      .clk       (clk),
      .reset     (rst_n),
      .pat_valid (pat_valid),
      .pat_ready (pat_ready),
      .pat_data  (pat_data),
      .pat_last  (pat_last),
      .pat_hold  (pat_hold),
      .dut_in    (dut_in),
      .dut_out   (dut_out),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .sig       (sig),
      .sig_valid (sig_valid),
      .busy      (busy)
   );

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) dp <= '0;
      else        dp <= dp ^ dut_in;
   assign dut_out = dp[OUT_W-1:0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // MISR step as polynomial arithmetic: multiply by x mod (x^11 + x^2 + 1).
   function automatic logic [OUT_W-1:0] misr(input logic [OUT_W-1:0] s,
                                             input logic [OUT_W-1:0] d);
      logic [OUT_W:0] t;
      t = {s, 1'b0};
      if (t[OUT_W]) t = t ^ 12'h805;
      return t[OUT_W-1:0] ^ d;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rst_pat_ready", 32'(pat_ready), 32'd1);
      chk("rst_outs", {rsp_valid, sig_valid, busy, dut_in, rsp_data}, 32'd0);
      chk("rst_sig", 32'(sig), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_acc = '0;
      m_sig = '0;
      m_first = 1'b1;
   endtask

   task automatic send(input logic [IN_W-1:0] p, input logic last,
                       input logic [3:0] h, input int stall);
      int lat;
      int guard;
      logic [IN_W-1:0] dp_snap;
      guard = 0;
      while (!pat_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("ready_wait", 32'(pat_ready), 32'd1);
      pat_valid = 1'b1;
      pat_data  = p;
      pat_last  = last;
      pat_hold  = h;
      @(posedge clk);
      @(negedge clk);
      pat_valid = 1'b0;
      pat_data  = $urandom;
      chk("apply_din", 32'(dut_in), 32'(p));
      chk("apply_busy", {busy, pat_ready}, 32'b10);
      lat = 1;
      while (!rsp_valid && lat < 40) begin
         @(posedge clk);
         @(negedge clk);
         lat++;
         if (dut_in !== '0) chk("wait_din", 32'(dut_in), 32'd0);
      end
      chk("rsp_latency", 32'(lat), 32'(3 + h));
      m_acc = m_acc ^ p;
      if (m_first) begin
         m_sig = '0;
         m_first = 1'b0;
      end
      m_sig = misr(m_sig, m_acc[OUT_W-1:0]);
      chk("rsp_data", 32'(rsp_data), 32'(m_acc[OUT_W-1:0]));
      last_rsp = rsp_data;
      dp_snap = dp;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk("stall", {rsp_valid, pat_ready, rsp_data, dut_in},
             {1'b1, 1'b0, m_acc[OUT_W-1:0], 19'd0});
         chk("stall_dp", 32'(dp), 32'(dp_snap));
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      if (last) begin
         chk("sig_valid", {sig_valid, rsp_valid, pat_ready}, 32'b100);
         chk("sig", 32'(sig), 32'(m_sig));
         last_sig = sig;
         m_first = 1'b1;
         @(negedge clk);
         chk("post_done", {sig_valid, pat_ready, busy}, 32'b010);
         chk("sig_hold", 32'(sig), 32'(m_sig));
      end else begin
         chk("next_ready", {sig_valid, pat_ready, busy, rsp_valid}, 32'b0100);
      end
   endtask

   task automatic abort_in_wait();
      pat_valid = 1'b1;
      pat_data  = 19'h12345;
      pat_last  = 1'b1;
      pat_hold  = 4'd15;
      @(posedge clk);
      @(negedge clk);
      pat_valid = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      chk("abort_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_outs", {rsp_valid, sig_valid, busy, pat_ready}, 32'b0001);
      chk("abort_din", 32'(dut_in), 32'd0);
      chk("abort_dp", 32'(dp), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_acc = '0;
      m_sig = '0;
      m_first = 1'b1;
      repeat (3) @(negedge clk);
      chk("abort_after", {rsp_valid, sig_valid, busy, pat_ready}, 32'b0001);
   endtask

   initial begin
      rst_n = 1'b0;
      pat_valid = 1'b0;
      pat_data = '0;
      pat_last = 1'b0;
      pat_hold = '0;
      rsp_ready = 1'b0;
      do_reset();

      send(19'h00001, 1'b1, 4'd0, 0);
      chk("t1_rsp", 32'(last_rsp), 32'h001);
      chk("t1_sig", 32'(last_sig), 32'h001);

      do_reset();
      send(19'h00003, 1'b0, 4'd2, 0);
      chk("t2_rsp0", 32'(last_rsp), 32'h003);
      send(19'h00001, 1'b1, 4'd2, 0);
      chk("t2_rsp1", 32'(last_rsp), 32'h002);
      chk("t2_sig", 32'(last_sig), 32'h004);

      send(19'h00010, 1'b1, 4'd0, 5);

      do_reset();
      send(19'h7F800, 1'b1, 4'd1, 0);
      chk("t4_rsp", 32'(last_rsp), 32'h000);
      chk("t4_sig", 32'(last_sig), 32'h000);
      chk("t4_upper", 32'(dp[IN_W-1:OUT_W]), 32'hFF);

      do_reset();
      send(19'h00400, 1'b0, 4'd0, 0);
      send(19'h00400, 1'b1, 4'd0, 0);
      chk("t5_sig", 32'(last_sig), 32'h005);

      abort_in_wait();
      send(19'h00006, 1'b1, 4'd0, 0);
      chk("t6_sig", 32'(last_sig), 32'h006);

      for (int n = 0; n < 60; n++) begin
         send(IN_W'($urandom), ($urandom % 4) == 0,
              4'($urandom_range(0, 15)), $urandom_range(0, 3));
      end
      send(IN_W'($urandom), 1'b1, 4'd3, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
